id_ex_stage: RTL

- ID/EX pipeline register for the MIPS_32 core, directly downstream of the register file.
- Captures the two register-file read operands with the decoded instruction fields, and bypasses a same-cycle writeback so a write and read of the same register in one cycle return the new value.
- Detects load-use hazards, inserts bubbles, and holds or flushes on request.
- Output feeds the EX stage (ALU and forwarding muxes).

---
 rtl/mips_pkg.sv | 40 ++++
 rtl/id_ex_stage_if.sv | 68 ++++++
 rtl/id_ex_stage_operand_bypass.sv | 36 +++
 rtl/id_ex_stage.sv | 121 ++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS_32 ID/EX slice.
//   SIZE      : default datapath width (matches the register file)
//   CTRL_W    : width of the opaque EX control bundle (derived from ex_ctrl_t)
//   CNT_W     : default width of the saturating bubble counter
//   REG_ZERO  : hard-wired zero register index
//   ex_ctrl_t : field layout of the EX control bundle
//   bypass_hit: true when a writeback should override a register-file read
// ---------------------------------------------------------------------------
package mips_pkg;

   localparam int SIZE  = 32;
   localparam int CNT_W = 16;
   localparam int REG_W = 5;

   typedef logic [REG_W-1:0] reg_idx_t;

   localparam reg_idx_t REG_ZERO = 5'd0;

   // EX control bundle; the ID/EX stage passes it through untouched and
   // forces it to all-zero on a bubble so the EX stage performs no action.
   typedef struct packed {
      logic [3:0] alu_op;
      logic       alu_src;
      logic       reg_dst;
      logic       mem_write;
      logic       mem_to_reg;
   } ex_ctrl_t;

   localparam int CTRL_W = $bits(ex_ctrl_t);

   // Register 0 is never bypassed: it always reads as zero.
   function automatic logic bypass_hit(input reg_idx_t idx,
                                       input logic     wb_we,
                                       input reg_idx_t wb_reg);
      return wb_we && (wb_reg == idx) && (idx != REG_ZERO);
   endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ---------------------------------------------------------------------------
// id_ex_stage_if
// Bundles every ID-side input, writeback bypass input, pipeline control and
// EX-side output of the ID/EX stage.
//   master : the surrounding pipeline (drives id_*, wb_*, hold, flush)
//   slave  : the id_ex_stage itself (drives ex_*, load_use_stall,
//            bubble_count)
// ---------------------------------------------------------------------------
interface id_ex_stage_if #(
   parameter int SIZE   = mips_pkg::SIZE,
   parameter int CTRL_W = mips_pkg::CTRL_W,
   parameter int CNT_W  = mips_pkg::CNT_W
) ();
   import mips_pkg::reg_idx_t;

   // ID side
   logic              id_valid;
   reg_idx_t          id_rs;
   reg_idx_t          id_rt;
   logic              id_usesRt;
   reg_idx_t          id_dest;
   logic [SIZE-1:0]   id_readData1;
   logic [SIZE-1:0]   id_readData2;
   logic [SIZE-1:0]   id_imm;
   logic [CTRL_W-1:0] id_ctrl;
   logic              id_memRead;
   logic              id_regWrite;

   // Writeback bypass
   logic              wb_regWrite;
   reg_idx_t          wb_writeReg;
   logic [SIZE-1:0]   wb_writeData;

   // Pipeline control
   logic              hold;
   logic              flush;

   // EX side
   logic              ex_valid;
   reg_idx_t          ex_rs;
   reg_idx_t          ex_rt;
   reg_idx_t          ex_dest;
   logic [SIZE-1:0]   ex_opA;
   logic [SIZE-1:0]   ex_opB;
   logic [SIZE-1:0]   ex_imm;
   logic [CTRL_W-1:0] ex_ctrl;
   logic              ex_memRead;
   logic              ex_regWrite;
   logic              load_use_stall;
   logic [CNT_W-1:0]  bubble_count;

   modport master (
      output id_valid, id_rs, id_rt, id_usesRt, id_dest, id_readData1,
             id_readData2, id_imm, id_ctrl, id_memRead, id_regWrite,
             wb_regWrite, wb_writeReg, wb_writeData, hold, flush,
      input  ex_valid, ex_rs, ex_rt, ex_dest, ex_opA, ex_opB, ex_imm,
             ex_ctrl, ex_memRead, ex_regWrite, load_use_stall, bubble_count
   );

   modport slave (
      input  id_valid, id_rs, id_rt, id_usesRt, id_dest, id_readData1,
             id_readData2, id_imm, id_ctrl, id_memRead, id_regWrite,
             wb_regWrite, wb_writeReg, wb_writeData, hold, flush,
      output ex_valid, ex_rs, ex_rt, ex_dest, ex_opA, ex_opB, ex_imm,
             ex_ctrl, ex_memRead, ex_regWrite, load_use_stall, bubble_count
   );

endinterface

// File: rtl/id_ex_stage_operand_bypass.sv
// ---------------------------------------------------------------------------
// operand_bypass
// Per-source operand select in front of the ID/EX register: register 0 reads
// as zero, a same-cycle writeback to the source register wins over the
// register-file value, otherwise the register-file value passes through.
//   idx           : source register index
//   rf_data       : register-file read data for idx
//   wb_reg_write  : writeback enable
//   wb_write_reg  : writeback destination
//   wb_write_data : writeback data
//   operand       : selected operand
// ---------------------------------------------------------------------------
module operand_bypass
   import mips_pkg::reg_idx_t, mips_pkg::REG_ZERO, mips_pkg::bypass_hit;
#(
   parameter int SIZE = mips_pkg::SIZE
) (
   input  reg_idx_t        idx,
   input  logic [SIZE-1:0] rf_data,
   input  logic            wb_reg_write,
   input  reg_idx_t        wb_write_reg,
   input  logic [SIZE-1:0] wb_write_data,
   output logic [SIZE-1:0] operand
);

   always_comb begin
      // NOTE: default first so every path assigns operand and no latch is inferred.
      operand = rf_data;
      if (idx == REG_ZERO) begin
         operand = '0;
      end else if (bypass_hit(idx, wb_reg_write, wb_write_reg)) begin
         operand = wb_write_data;
      end
   end

endmodule

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register of the MIPS_32 core. Captures bypassed operands,
// immediate, register indices and the EX control bundle; detects load-use
// hazards and inserts bubbles; honours hold (freeze) and flush (squash).
//   clk   : rising-edge clock
//   reset : asynchronous, active-high reset
//   bus   : id_ex_stage_if.slave (ID inputs, WB bypass, hold/flush,
//           EX outputs, load_use_stall, bubble_count)
// Priority per edge: flush > hold > load-use bubble > load from ID.
// ---------------------------------------------------------------------------
module id_ex_stage
   import mips_pkg::reg_idx_t, mips_pkg::REG_ZERO;
#(
   parameter int SIZE   = mips_pkg::SIZE,
   parameter int CTRL_W = mips_pkg::CTRL_W,
   parameter int CNT_W  = mips_pkg::CNT_W
) (
   input logic          clk,
   input logic          reset,
   id_ex_stage_if.slave bus
);

   logic [SIZE-1:0]   op_a;
   logic [SIZE-1:0]   op_b;
   logic              stall;

   logic              ex_valid_q;
   reg_idx_t          ex_rs_q;
   reg_idx_t          ex_rt_q;
   reg_idx_t          ex_dest_q;
   logic [SIZE-1:0]   ex_op_a_q;
   logic [SIZE-1:0]   ex_op_b_q;
   logic [SIZE-1:0]   ex_imm_q;
   logic [CTRL_W-1:0] ex_ctrl_q;
   logic              ex_mem_read_q;
   logic              ex_reg_write_q;
   logic [CNT_W-1:0]  bubble_count_q;

   operand_bypass #(.SIZE(SIZE)) u_bypass_a (
      .idx           (bus.id_rs),
      .rf_data       (bus.id_readData1),
      .wb_reg_write  (bus.wb_regWrite),
      .wb_write_reg  (bus.wb_writeReg),
      .wb_write_data (bus.wb_writeData),
      .operand       (op_a)
   );

   operand_bypass #(.SIZE(SIZE)) u_bypass_b (
      .idx           (bus.id_rt),
      .rf_data       (bus.id_readData2),
      .wb_reg_write  (bus.wb_regWrite),
      .wb_write_reg  (bus.wb_writeReg),
      .wb_write_data (bus.wb_writeData),
      .operand       (op_b)
   );

   // A load in EX whose result is needed by the instruction in ID. Once the
   // bubble enters EX, ex_valid_q drops and the stall releases by itself.
   assign stall = ex_valid_q && ex_mem_read_q && (ex_dest_q != REG_ZERO) &&
                  bus.id_valid &&
                  ((ex_dest_q == bus.id_rs) ||
                   (bus.id_usesRt && (ex_dest_q == bus.id_rt)));

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ex_valid_q     <= 1'b0;
         ex_rs_q        <= '0;
         ex_rt_q        <= '0;
         ex_dest_q      <= '0;
         ex_op_a_q      <= '0;
         ex_op_b_q      <= '0;
         ex_imm_q       <= '0;
         ex_ctrl_q      <= '0;
         ex_mem_read_q  <= 1'b0;
         ex_reg_write_q <= 1'b0;
         bubble_count_q <= '0;
      end else begin
         if (bus.flush || (!bus.hold && stall)) begin
            // Bubble: only the fields that can cause side effects are cleared.
            ex_valid_q     <= 1'b0;
            ex_ctrl_q      <= '0;
            ex_mem_read_q  <= 1'b0;
            ex_reg_write_q <= 1'b0;
         end else if (!bus.hold) begin
            ex_valid_q     <= bus.id_valid;
            ex_rs_q        <= bus.id_rs;
            ex_rt_q        <= bus.id_rt;
            ex_dest_q      <= bus.id_dest;
            ex_op_a_q      <= op_a;
            ex_op_b_q      <= op_b;
            ex_imm_q       <= bus.id_imm;
            ex_ctrl_q      <= bus.id_ctrl;
            ex_mem_read_q  <= bus.id_memRead && bus.id_valid;
            ex_reg_write_q <= bus.id_regWrite && bus.id_valid;
         end

         // Only bubbles caused by the hazard are counted, and the count
         // sticks at all-ones instead of wrapping.
         if (!bus.flush && !bus.hold && stall && (bubble_count_q != '1)) begin
            bubble_count_q <= bubble_count_q + CNT_W'(1);
         end
      end
   end

   assign bus.ex_valid       = ex_valid_q;
   assign bus.ex_rs          = ex_rs_q;
   assign bus.ex_rt          = ex_rt_q;
   assign bus.ex_dest        = ex_dest_q;
   assign bus.ex_opA         = ex_op_a_q;
   assign bus.ex_opB         = ex_op_b_q;
   assign bus.ex_imm         = ex_imm_q;
   assign bus.ex_ctrl        = ex_ctrl_q;
   assign bus.ex_memRead     = ex_mem_read_q;
   assign bus.ex_regWrite    = ex_reg_write_q;
   assign bus.load_use_stall = stall;
   assign bus.bubble_count   = bubble_count_q;

endmodule
